move_commit_ctrl: RTL and testbench
===================================

Name: move_commit_ctrl

Overview:
- Sequential initiator for the combinational tile-interaction resolver; owns the player state registers (floor, position, keys, health).
- Accepts a one-step move request and computes the target tile.
- Reads the target tile from the map RAM, presents the current state plus tile to the resolver, and commits the resolver's outputs.
- Writes the changed tile back to the map and signals completion; sits between the keyboard/input decoder and the map RAM/renderer.

Parameters:
FLOOR_W, 4, floor index bits used in the map address
START_FLOOR, 0, floor after reset
START_X, 5, player x after reset
START_Y, 10, player y after reset
START_HEALTH, 100, health after reset

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
move_valid  in  1  move request strobe
move_dir  in  2  0=up(y-1) 1=down(y+1) 2=left(x-1) 3=right(x+1)
move_ready  out  1  high when request can be accepted (state IDLE)
move_done  out  1  one-cycle pulse at end of every accepted request
move_blocked  out  1  valid with move_done; 1 = position and floor unchanged
map_raddr  out  FLOOR_W+8  {floor, y, x} read address; RAM has 1-cycle read latency
map_rdata  in  16  tile id read data
map_we  out  1  tile write strobe
map_waddr  out  FLOOR_W+8  {floor, y, x} write address
map_wdata  out  16  tile id to write
res_pos_x / res_pos_y  out  4 each  target coordinates to resolver
res_tile_id  out  16  captured target tile
res_floor  out  16  current floor
res_player_x / res_player_y  out  4 each  current position
res_key_num  out  32  current key counts
res_health  out  16  current health
res_floor_out  in  16  resolver result floor
res_goto_x / res_goto_y  in  4 each  resolver result position
res_key_num_out  in  32  resolver result keys
res_health_out  in  16  resolver result health
res_new_tile_id  in  16  resolver result tile
floor, player_x, player_y, key_num, health  out  16/4/4/32/16  committed state for display

Behaviour:
- The resolver is purely combinational; res_* outputs are driven directly from the registers.
- Reset (rst_n low at a clk edge, any state): state=IDLE; floor=START_FLOOR; player_x=START_X; player_y=START_Y; key_num=0; health=START_HEALTH; tile and target registers=0; move_done=0; move_blocked=0; map_we=0. An in-flight move is abandoned with no write.
- IDLE: move_ready=1.
  - move_valid with in-bounds target: latch tx/ty, go RD.
  - Out-of-bounds target (x=0 left, x=15 right, y=0 up, y=15 down): go DONE with blocked=1; no RAM access.
  - move_valid outside IDLE is ignored; no queueing.
- RD: map_raddr={floor[FLOOR_W-1:0],ty,tx}; go WT.
- WT: tile_reg<=map_rdata; go EXE.
- EXE:
  - Commit floor, player_x/y, key_num, health from res_* inputs.
  - If res_new_tile_id != tile_reg: map_we=1 for this cycle, map_waddr=the pre-commit floor with ty,tx, map_wdata=res_new_tile_id.
  - blocked = (res_goto_x==player_x && res_goto_y==player_y && res_floor_out==floor).
  - Go DONE.
- DONE: move_done=1, move_blocked=blocked; go IDLE.
- Latency: request sampled in IDLE at edge N → move_done high in cycle N+4 (N+1 for out-of-bounds); back in IDLE at N+5. Max throughput is one move per 5 cycles.
- The resolver owns arithmetic, including wrap of keys and health; the controller does no saturation.
- The stair case (floor change) writes back only if the tile changed, always to the old floor.
- move_done, move_blocked, and map_we are registered-state decodes, low in every other state.

Test Plan:
1. Reset with START_X=5, START_Y=10; tile (5,9) = ground; move_dir=0 → map_raddr={0,9,5} in RD, move_done at N+4, blocked=0, player=(5,9), map_we never asserted.
2. Target tile is key_0, keys=0 → key_num[7:0]=1, map_we pulse in EXE with waddr={0,9,5} and wdata=ground id, player moved.
3. Target is door_0 with keys=0 → map_we=0, blocked=1, position and keys unchanged; repeat with keys=1 → keys=0, door cleared, moved.
4. Player at x=0, move_dir=2 → move_done at N+1, blocked=1, no map_raddr cycle, no write.
5. Target is upstair on floor 0 → floor=1, position = resolver goto, blocked=0, no write.
6. Assert move_valid on every cycle during a move → exactly one move_done per 5 cycles; assert rst_n=0 during WT → all outputs at reset values next cycle, no map_we.

Source files
------------

// File: rtl/move_commit_ctrl.sv
// rtl/move_commit_ctrl.sv - player move sequencer: tile read, resolver commit, tile write-back
module move_commit_ctrl #(
   parameter int FLOOR_W      = 4,
   parameter int START_FLOOR  = 0,
   parameter int START_X      = 5,
   parameter int START_Y      = 10,
   parameter int START_HEALTH = 100
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 move_valid,
   input  logic [1:0]           move_dir,
   output logic                 move_ready,
   output logic                 move_done,
   output logic                 move_blocked,
   output logic [FLOOR_W+7:0]   map_raddr,
   input  logic [15:0]          map_rdata,
   output logic                 map_we,
   output logic [FLOOR_W+7:0]   map_waddr,
   output logic [15:0]          map_wdata,
   output logic [3:0]           res_pos_x,
   output logic [3:0]           res_pos_y,
   output logic [15:0]          res_tile_id,
   output logic [15:0]          res_floor,
   output logic [3:0]           res_player_x,
   output logic [3:0]           res_player_y,
   output logic [31:0]          res_key_num,
   output logic [15:0]          res_health,
   input  logic [15:0]          res_floor_out,
   input  logic [3:0]           res_goto_x,
   input  logic [3:0]           res_goto_y,
   input  logic [31:0]          res_key_num_out,
   input  logic [15:0]          res_health_out,
   input  logic [15:0]          res_new_tile_id,
   output logic [15:0]          floor,
   output logic [3:0]           player_x,
   output logic [3:0]           player_y,
   output logic [31:0]          key_num,
   output logic [15:0]          health
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WT   = 3'd2,
      S_EXE  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   floor_q, floor_d;
   logic [3:0]    x_q, x_d;
   logic [3:0]    y_q, y_d;
   logic [31:0]   keys_q, keys_d;
   logic [15:0]   health_q, health_d;
   logic [15:0]   tile_q, tile_d;
   logic [3:0]    tx_q, tx_d;
   logic [3:0]    ty_q, ty_d;
   logic          blocked_q, blocked_d;

   // Target tile for the requested direction and whether it leaves the 16x16 grid.
   logic [3:0]    req_tx;
   logic [3:0]    req_ty;
   logic          req_oob;

   // Decode the one-step target from the current position.
   always_comb begin
      req_tx  = x_q;
      req_ty  = y_q;
      req_oob = 1'b0;
      case (move_dir)
         2'd0: begin
            req_oob = (y_q == 4'd0);
            req_ty  = y_q - 4'd1;
         end
         2'd1: begin
            req_oob = (y_q == 4'd15);
            req_ty  = y_q + 4'd1;
         end
         2'd2: begin
            req_oob = (x_q == 4'd0);
            req_tx  = x_q - 4'd1;
         end
         default: begin
            req_oob = (x_q == 4'd15);
            req_tx  = x_q + 4'd1;
         end
      endcase
   end

   // Sequence one move: read tile, wait for RAM, commit resolver result, report.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      x_d       = x_q;
      y_d       = y_q;
      keys_d    = keys_q;
      health_d  = health_q;
      tile_d    = tile_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      blocked_d = blocked_q;

      move_ready   = (state_q == S_IDLE);
      move_done    = (state_q == S_DONE);
      move_blocked = (state_q == S_DONE) && blocked_q;
      // Only a changed tile is written; the address still carries the old floor
      // because the floor register updates on the same edge that ends EXE.
      map_we       = (state_q == S_EXE) && (res_new_tile_id != tile_q);

      case (state_q)
         S_IDLE: begin
            if (move_valid) begin
               if (req_oob) begin
                  // Edge of the map: report a blocked move without touching RAM.
                  blocked_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  tx_d    = req_tx;
                  ty_d    = req_ty;
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_WT;
         end
         S_WT: begin
            tile_d  = map_rdata;
            state_d = S_EXE;
         end
         S_EXE: begin
            floor_d   = res_floor_out;
            x_d       = res_goto_x;
            y_d       = res_goto_y;
            keys_d    = res_key_num_out;
            health_d  = res_health_out;
            blocked_d = (res_goto_x == x_q) && (res_goto_y == y_q) &&
                        (res_floor_out == floor_q);
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and player registers; reset abandons any move in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         floor_q   <= 16'(START_FLOOR);
         x_q       <= 4'(START_X);
         y_q       <= 4'(START_Y);
         keys_q    <= 32'd0;
         health_q  <= 16'(START_HEALTH);
         tile_q    <= 16'd0;
         tx_q      <= 4'd0;
         ty_q      <= 4'd0;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         x_q       <= x_d;
         y_q       <= y_d;
         keys_q    <= keys_d;
         health_q  <= health_d;
         tile_q    <= tile_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         blocked_q <= blocked_d;
      end
   end

   assign map_raddr    = {floor_q[FLOOR_W-1:0], ty_q, tx_q};
   assign map_waddr    = {floor_q[FLOOR_W-1:0], ty_q, tx_q};
   assign map_wdata    = res_new_tile_id;

   assign res_pos_x    = tx_q;
   assign res_pos_y    = ty_q;
   assign res_tile_id  = tile_q;
   assign res_floor    = floor_q;
   assign res_player_x = x_q;
   assign res_player_y = y_q;
   assign res_key_num  = keys_q;
   assign res_health   = health_q;

   assign floor        = floor_q;
   assign player_x     = x_q;
   assign player_y     = y_q;
   assign key_num      = keys_q;
   assign health       = health_q;

endmodule

// File: tb/tb_move_commit_ctrl.sv
// tb/tb_move_commit_ctrl.sv - randomized self-checking bench for move_commit_ctrl
module tb_move_commit_ctrl;

   localparam logic [15:0] T_GROUND = 16'd0;
   localparam logic [15:0] T_WALL   = 16'd1;
   localparam logic [15:0] T_KEY    = 16'd2;
   localparam logic [15:0] T_DOOR   = 16'd3;
   localparam logic [15:0] T_UP     = 16'd4;
   localparam logic [15:0] T_POTION = 16'd5;
   localparam logic [15:0] T_DOWN   = 16'd6;
   localparam logic [15:0] T_MONSTER= 16'd7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        move_valid = 1'b0;
   logic [1:0]  move_dir = 2'd0;
   logic        move_ready, move_done, move_blocked;
   logic [11:0] map_raddr, map_waddr;
   logic [15:0] map_rdata = 16'd0;
   logic        map_we;
   logic [15:0] map_wdata;
   logic [3:0]  res_pos_x, res_pos_y, res_player_x, res_player_y;
   logic [15:0] res_tile_id, res_floor, res_health;
   logic [31:0] res_key_num;
   logic [15:0] res_floor_out, res_health_out, res_new_tile_id;
   logic [3:0]  res_goto_x, res_goto_y;
   logic [31:0] res_key_num_out;
   logic [15:0] floor, health;
   logic [3:0]  player_x, player_y;
   logic [31:0] key_num;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:4095];

   logic [15:0] m_floor, m_hp;
   logic [3:0]  m_x, m_y;
   logic [31:0] m_keys;

   typedef struct packed {
      logic [15:0] fl;
      logic [3:0]  gx;
      logic [3:0]  gy;
      logic [31:0] k;
      logic [15:0] hp;
      logic [15:0] nt;
   } res_t;

   res_t rr;

   move_commit_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .move_valid(move_valid), .move_dir(move_dir),
      .move_ready(move_ready), .move_done(move_done), .move_blocked(move_blocked),
      .map_raddr(map_raddr), .map_rdata(map_rdata),
      .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
      .res_pos_x(res_pos_x), .res_pos_y(res_pos_y), .res_tile_id(res_tile_id),
      .res_floor(res_floor), .res_player_x(res_player_x), .res_player_y(res_player_y),
      .res_key_num(res_key_num), .res_health(res_health),
      .res_floor_out(res_floor_out), .res_goto_x(res_goto_x), .res_goto_y(res_goto_y),
      .res_key_num_out(res_key_num_out), .res_health_out(res_health_out),
      .res_new_tile_id(res_new_tile_id),
      .floor(floor), .player_x(player_x), .player_y(player_y),
      .key_num(key_num), .health(health)
   );

   always #5 clk = ~clk;

   // Tile rules of the external resolver, used both to drive the DUT and to predict.
   function automatic res_t resolve(input logic [15:0] tile, input logic [15:0] fl,
                                    input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] tx, input logic [3:0] ty,
                                    input logic [31:0] k, input logic [15:0] hp);
      res_t r;
      r.fl = fl; r.gx = px; r.gy = py; r.k = k; r.hp = hp; r.nt = tile;
      case (tile)
         T_WALL: ;
         T_KEY: begin r.k = k + 32'd1; r.nt = T_GROUND; r.gx = tx; r.gy = ty; end
         T_DOOR: if (k[7:0] != 8'd0) begin
            r.k = k - 32'd1; r.nt = T_GROUND; r.gx = tx; r.gy = ty;
         end
         T_UP: begin r.fl = fl + 16'd1; r.gx = tx; r.gy = ty; end
         T_POTION: begin r.hp = hp + 16'd10; r.nt = T_GROUND; r.gx = tx; r.gy = ty; end
         T_DOWN: if (fl != 16'd0) begin r.fl = fl - 16'd1; r.gx = tx; r.gy = ty; end
         T_MONSTER: begin r.hp = hp - 16'd7; r.nt = T_GROUND; end
         default: begin r.gx = tx; r.gy = ty; end
      endcase
      return r;
   endfunction

   // Combinational resolver attached to the DUT.
   always_comb begin
      rr = resolve(res_tile_id, res_floor, res_player_x, res_player_y,
                   res_pos_x, res_pos_y, res_key_num, res_health);
   end
   assign res_floor_out   = rr.fl;
   assign res_goto_x      = rr.gx;
   assign res_goto_y      = rr.gy;
   assign res_key_num_out = rr.k;
   assign res_health_out  = rr.hp;
   assign res_new_tile_id = rr.nt;

   // Map RAM read port with one cycle of latency.
   always @(posedge clk) map_rdata <= mem[map_raddr];

   task automatic model_reset();
      m_floor = 16'd0; m_x = 4'd5; m_y = 4'd10; m_keys = 32'd0; m_hp = 16'd100;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; move_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_tile(input logic [3:0] fl, input logic [3:0] x, input logic [3:0] y,
                           input logic [15:0] t);
      mem[{fl, y, x}] = t;
   endtask

   // Predict one move from the game rules; updates the model state.
   task automatic ref_step(input logic [1:0] dir, output bit oob, output bit blk, output bit wr,
                           output logic [11:0] ra, output logic [15:0] wd);
      logic [3:0] tx, ty;
      logic [15:0] t;
      res_t r;
      tx = m_x; ty = m_y; oob = 0;
      case (dir)
         2'd0: if (m_y == 4'd0) oob = 1; else ty = m_y - 4'd1;
         2'd1: if (m_y == 4'd15) oob = 1; else ty = m_y + 4'd1;
         2'd2: if (m_x == 4'd0) oob = 1; else tx = m_x - 4'd1;
         default: if (m_x == 4'd15) oob = 1; else tx = m_x + 4'd1;
      endcase
      ra = {m_floor[3:0], ty, tx};
      wr = 0; wd = 16'd0; blk = 1;
      if (!oob) begin
         t = mem[ra];
         r = resolve(t, m_floor, m_x, m_y, tx, ty, m_keys, m_hp);
         wr = (r.nt != t);
         wd = r.nt;
         blk = (r.gx == m_x) && (r.gy == m_y) && (r.fl == m_floor);
         m_floor = r.fl; m_x = r.gx; m_y = r.gy; m_keys = r.k; m_hp = r.hp;
      end
   endtask

   task automatic do_move(input logic [1:0] dir);
      bit oob, blk, wr;
      logic [11:0] ra, got_wa;
      logic [15:0] wd, got_wd;
      int done_k, we_cnt, w;
      w = 0;
      while (move_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (move_ready !== 1'b1) begin
         errors++; $display("FAIL ready_wait: move_ready=%b required 1", move_ready);
      end
      ref_step(dir, oob, blk, wr, ra, wd);
      move_dir = dir; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      done_k = 0; we_cnt = 0; got_wa = '0; got_wd = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 1 && !oob) begin
            checks++;
            if (map_raddr !== ra) begin
               errors++; $display("FAIL raddr: got %h required %h", map_raddr, ra);
            end
         end
         if (map_we === 1'b1) begin we_cnt++; got_wa = map_waddr; got_wd = map_wdata; end
         if (move_done === 1'b1) begin done_k = k; break; end
         @(negedge clk);
      end
      checks++;
      if (done_k != (oob ? 1 : 4)) begin
         errors++; $display("FAIL latency: done at %0d required %0d", done_k, oob ? 1 : 4);
      end
      checks++;
      if (move_blocked !== blk) begin
         errors++; $display("FAIL blocked: got %b required %b", move_blocked, blk);
      end
      checks++;
      if (we_cnt != int'(wr)) begin
         errors++; $display("FAIL we_count: got %0d required %0d", we_cnt, wr);
      end
      if (wr) begin
         checks++;
         if (got_wa !== ra || got_wd !== wd) begin
            errors++;
            $display("FAIL write: addr %h data %h required addr %h data %h", got_wa, got_wd, ra, wd);
         end
      end
      checks++;
      if ({floor, player_x, player_y, key_num, health} !== {m_floor, m_x, m_y, m_keys, m_hp}) begin
         errors++;
         $display("FAIL state: fl %0d x %0d y %0d k %0d hp %0d required fl %0d x %0d y %0d k %0d hp %0d",
                  floor, player_x, player_y, key_num, health, m_floor, m_x, m_y, m_keys, m_hp);
      end
      if (wr) mem[ra] = wd;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({move_ready, move_done, move_blocked, map_we} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: ready/done/blocked/we=%b required 1000",
                  {move_ready, move_done, move_blocked, map_we});
      end
      checks++;
      if ({floor, player_x, player_y, key_num, health} !== {16'd0, 4'd5, 4'd10, 32'd0, 16'd100}) begin
         errors++;
         $display("FAIL reset_state: fl %0d x %0d y %0d k %0d hp %0d required 0 5 10 0 100",
                  floor, player_x, player_y, key_num, health);
      end
      checks++;
      if ({res_tile_id, res_pos_x, res_pos_y} !== 24'd0) begin
         errors++;
         $display("FAIL reset_regs: tile %h tx %0d ty %0d required 0", res_tile_id, res_pos_x, res_pos_y);
      end
   endtask

   task automatic test_ground();
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_GROUND);
      do_move(2'd0);
   endtask

   task automatic test_key();
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_KEY);
      do_move(2'd0);
      checks++;
      if (key_num[7:0] !== 8'd1) begin
         errors++; $display("FAIL key_count: got %0d required 1", key_num[7:0]);
      end
   endtask

   task automatic test_door();
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_DOOR);
      set_tile(4'd0, 4'd5, 4'd11, T_KEY);
      set_tile(4'd0, 4'd5, 4'd10, T_GROUND);
      do_move(2'd0);
      do_move(2'd1);
      do_move(2'd0);
      do_move(2'd0);
      checks++;
      if ({player_y, key_num, mem[{4'd0, 4'd9, 4'd5}]} !== {4'd9, 32'd0, T_GROUND}) begin
         errors++;
         $display("FAIL door_open: y %0d keys %0d required y 9 keys 0", player_y, key_num);
      end
   endtask

   task automatic test_oob();
      apply_reset();
      for (int x = 0; x < 5; x++) set_tile(4'd0, 4'(x), 4'd10, T_GROUND);
      for (int i = 0; i < 5; i++) do_move(2'd2);
      do_move(2'd2);
      checks++;
      if (player_x !== 4'd0) begin
         errors++; $display("FAIL oob_pos: x %0d required 0", player_x);
      end
   endtask

   task automatic test_stairs();
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_UP);
      do_move(2'd0);
      checks++;
      if (floor !== 16'd1) begin
         errors++; $display("FAIL stair_floor: got %0d required 1", floor);
      end
   endtask

   task automatic test_back_to_back();
      bit oob, blk, wr;
      logic [11:0] ra;
      logic [15:0] wd;
      int dones, last, we_cnt, cyc;
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_GROUND);
      set_tile(4'd0, 4'd5, 4'd10, T_GROUND);
      move_dir = 2'd0; move_valid = 1'b1;
      dones = 0; last = -1; we_cnt = 0; cyc = 0;
      while (dones < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (map_we === 1'b1) we_cnt++;
         if (move_done === 1'b1) begin
            ref_step(move_dir, oob, blk, wr, ra, wd);
            if (last >= 0) begin
               checks++;
               if (cyc - last != 5) begin
                  errors++; $display("FAIL b2b_spacing: got %0d required 5", cyc - last);
               end
            end
            checks++;
            if ({move_blocked, player_x, player_y} !== {blk, m_x, m_y}) begin
               errors++;
               $display("FAIL b2b_state: blk %b x %0d y %0d required %b %0d %0d",
                        move_blocked, player_x, player_y, blk, m_x, m_y);
            end
            last = cyc; dones++;
            move_dir = (move_dir == 2'd0) ? 2'd1 : 2'd0;
         end
      end
      move_valid = 1'b0;
      checks++;
      if (dones != 6 || we_cnt != 0) begin
         errors++; $display("FAIL b2b_count: dones %0d we %0d required 6 0", dones, we_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midmove();
      bit saw_we;
      apply_reset();
      set_tile(4'd0, 4'd5, 4'd9, T_KEY);
      move_dir = 2'd0; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      saw_we = map_we;
      @(negedge clk);
      saw_we = saw_we | map_we;
      rst_n = 1'b0;
      @(negedge clk);
      saw_we = saw_we | map_we;
      checks++;
      if ({move_ready, move_done, move_blocked, saw_we} !== 4'b1000) begin
         errors++;
         $display("FAIL midreset_ctrl: ready/done/blocked/we=%b required 1000",
                  {move_ready, move_done, move_blocked, saw_we});
      end
      checks++;
      if ({player_x, player_y, key_num, res_tile_id} !== {4'd5, 4'd10, 32'd0, 16'd0}) begin
         errors++;
         $display("FAIL midreset_state: x %0d y %0d k %0d tile %h required 5 10 0 0",
                  player_x, player_y, key_num, res_tile_id);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_random();
      int r;
      apply_reset();
      for (int i = 0; i < 4096; i++) begin
         r = int'($urandom_range(0, 15));
         mem[i] = (r < 8) ? 16'd0 : 16'(r - 8);
      end
      for (int n = 0; n < 80; n++) do_move(2'($urandom_range(0, 3)));
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
      model_reset();
      test_reset();
      test_ground();
      test_key();
      test_door();
      test_oob();
      test_stairs();
      test_back_to_back();
      test_reset_midmove();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
